// File: rtl/compare_alarm_unit.sv
// Registered magnitude comparator feeding a three-state alarm FSM (IDLE/ARMED/FIRED).
// The FSM only ever sees registered ge/eq, so a-to-hit_pulse latency is two edges.
module compare_alarm_unit #(
  parameter int WIDTH      = 4,
  parameter bit AUTO_REARM = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] target_in,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic             arm,
  input  logic             disarm,
  input  logic             ack,
  output logic             ge,
  output logic             eq,
  output logic             hit_pulse,
  output logic             alarm,
  output logic             armed
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    FIRED = 2'b10
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] t_r;
  logic             ge_r;
  logic             eq_r;
  logic             hit_r;
  logic             alarm_r;
  logic             armed_r;
  logic             cond_s;

  // Target register: a newly loaded value is compared from the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_r <= {WIDTH{1'b0}};
    end else if (load) begin
      t_r <= target_in;
    end else begin
      t_r <= t_r;
    end
  end

  // Compare stage against the current target.
  always_ff @(posedge clk) begin
    if (rst) begin
      ge_r <= 1'b0;
      eq_r <= 1'b0;
    end else begin
      ge_r <= (a >= t_r);
      eq_r <= (a == t_r);
    end
  end

  // Fire condition selected from the registered compare flags.
  always_comb begin
    cond_s = 1'b0;
    case (mode)
      2'b00:   cond_s = ge_r;
      2'b01:   cond_s = eq_r;
      2'b10:   cond_s = ge_r & ~eq_r;
      2'b11:   cond_s = ~ge_r;
      default: cond_s = 1'b0;
    endcase
  end

  // Alarm FSM; outputs are registered alongside the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      hit_r   <= 1'b0;
      alarm_r <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      hit_r <= 1'b0;
      case (state_r)
        IDLE: begin
          alarm_r <= 1'b0;
          if (arm && !disarm) begin
            state_r <= ARMED;
            armed_r <= 1'b1;
          end else begin
            state_r <= IDLE;
            armed_r <= 1'b0;
          end
        end
        ARMED: begin
          if (disarm) begin
            state_r <= IDLE;
            armed_r <= 1'b0;
            alarm_r <= 1'b0;
          end else if (cond_s) begin
            state_r <= FIRED;
            armed_r <= 1'b0;
            alarm_r <= 1'b1;
            hit_r   <= 1'b1;
          end else begin
            state_r <= ARMED;
            armed_r <= 1'b1;
            alarm_r <= 1'b0;
          end
        end
        FIRED: begin
          if (disarm || ack) begin
            state_r <= IDLE;
            armed_r <= 1'b0;
            alarm_r <= 1'b0;
          end else if (AUTO_REARM && !cond_s) begin
            state_r <= ARMED;
            armed_r <= 1'b1;
            alarm_r <= 1'b0;
          end else begin
            state_r <= FIRED;
            armed_r <= 1'b0;
            alarm_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          armed_r <= 1'b0;
          alarm_r <= 1'b0;
        end
      endcase
    end
  end

  assign ge        = ge_r;
  assign eq        = eq_r;
  assign hit_pulse = hit_r;
  assign alarm     = alarm_r;
  assign armed     = armed_r;

endmodule

// File: tb/tb_compare_alarm_unit.sv
// Directed bench: u0 (WIDTH=4, latched alarm), u1 (WIDTH=4, auto re-arm), u2 (WIDTH=16).
module tb_compare_alarm_unit;

  logic        clk = 1'b0;
  logic        rst, load, arm, disarm, ack, load16;
  logic [1:0]  mode, mode16;
  logic [3:0]  a, target_in;
  logic [15:0] a16, t16;
  logic        ge0, eq0, hit0, alarm0, armed0;
  logic        ge1, eq1, hit1, alarm1, armed1;
  logic        ge2, eq2, hit2, alarm2, armed2;
  int          n_cmp = 0;
  int          n_err = 0;
  int          hits, hit_idx, hits1;

  always #5 clk = ~clk;

  compare_alarm_unit #(.WIDTH(4), .AUTO_REARM(1'b0)) u0 (
    .clk(clk), .rst(rst), .a(a), .target_in(target_in), .load(load), .mode(mode),
    .arm(arm), .disarm(disarm), .ack(ack), .ge(ge0), .eq(eq0), .hit_pulse(hit0),
    .alarm(alarm0), .armed(armed0));

  compare_alarm_unit #(.WIDTH(4), .AUTO_REARM(1'b1)) u1 (
    .clk(clk), .rst(rst), .a(a), .target_in(target_in), .load(load), .mode(mode),
    .arm(arm), .disarm(disarm), .ack(ack), .ge(ge1), .eq(eq1), .hit_pulse(hit1),
    .alarm(alarm1), .armed(armed1));

  compare_alarm_unit #(.WIDTH(16), .AUTO_REARM(1'b0)) u2 (
    .clk(clk), .rst(rst), .a(a16), .target_in(t16), .load(load16), .mode(mode16),
    .arm(arm), .disarm(disarm), .ack(ack), .ge(ge2), .eq(eq2), .hit_pulse(hit2),
    .alarm(alarm2), .armed(armed2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; arm = 1'b0; disarm = 1'b0; ack = 1'b0;
    mode = 2'b00; a = 4'd0; target_in = 4'd0;
    load16 = 1'b0; mode16 = 2'b00; a16 = 16'd0; t16 = 16'd0;
    tick();
    tick();
    chk("rst_ge", ge0, 1'b0);
    chk("rst_eq", eq0, 1'b0);
    chk("rst_hit", hit0, 1'b0);
    chk("rst_alarm", alarm0, 1'b0);
    chk("rst_armed", armed0, 1'b0);
    chk("rst_ge16", ge2, 1'b0);

    // T=9, mode >=, sweep a 0..15: single hit two edges after a=9
    rst = 1'b0; load = 1'b1; target_in = 4'd9;
    tick();
    load = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("sweep_armed", armed0, 1'b1);
    chk("sweep_ge0", ge0, 1'b0);
    hits = 0; hit_idx = -1;
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      tick();
      if (hit0) begin
        hits++;
        hit_idx = i;
      end
    end
    chk_int("sweep_hits", hits, 1);
    chk_int("sweep_hit_idx", hit_idx, 10);
    tick();
    tick();
    chk("sweep_alarm_hold", alarm0, 1'b1);
    chk("sweep_no_rehit", hit0, 1'b0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("arm_in_fired_ignored", alarm0, 1'b1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_alarm", alarm0, 1'b0);
    chk("ack_armed", armed0, 1'b0);

    // mode ==, T=5: stepping over 5 must not fire
    mode = 2'b01; load = 1'b1; target_in = 4'd5; a = 4'd3;
    tick();
    load = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
    hits = 0;
    a = 4'd4; tick(); hits += int'(hit0);
    a = 4'd6; tick(); hits += int'(hit0);
    tick(); hits += int'(hit0);
    chk_int("eq_skip_hits", hits, 0);
    chk("eq_skip_armed", armed0, 1'b1);
    a = 4'd5;
    tick();
    chk("eq_flag", eq0, 1'b1);
    chk("eq_no_early_hit", hit0, 1'b0);
    tick();
    chk("eq_hit", hit0, 1'b1);
    chk("eq_alarm", alarm0, 1'b1);
    tick();
    chk("eq_hit_one_cycle", hit0, 1'b0);
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
    chk("disarm_alarm", alarm0, 1'b0);

    // auto re-arm, T=7, a 8,2,8: two pulses on u1, armed in between
    mode = 2'b00; load = 1'b1; target_in = 4'd7; a = 4'd2;
    tick();
    load = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
    hits1 = 0;
    a = 4'd8; tick(); hits1 += int'(hit1);
    tick(); hits1 += int'(hit1);
    chk("rearm_first_hit", hit1, 1'b1);
    a = 4'd2; tick(); hits1 += int'(hit1);
    tick(); hits1 += int'(hit1);
    chk("rearm_armed_between", armed1, 1'b1);
    chk("rearm_alarm_low", alarm1, 1'b0);
    chk("latched_alarm_held", alarm0, 1'b1);
    a = 4'd8; tick(); hits1 += int'(hit1);
    tick(); hits1 += int'(hit1);
    chk_int("rearm_hits", hits1, 2);
    disarm = 1'b1;
    tick();
    disarm = 1'b0;

    // arm and reload T 3->10 on the same edge: a=3 must not fire under the new target
    load = 1'b1; target_in = 4'd3; a = 4'd2;
    tick();
    load = 1'b0;
    tick();
    arm = 1'b1; load = 1'b1; target_in = 4'd10;
    tick();
    arm = 1'b0; load = 1'b0;
    hits = 0;
    a = 4'd3; tick(); hits += int'(hit0);
    tick(); hits += int'(hit0);
    tick(); hits += int'(hit0);
    chk_int("reload_no_hit", hits, 0);
    chk("reload_armed", armed0, 1'b1);
    a = 4'd10;
    tick();
    tick();
    chk("reload_hit_at_10", hit0, 1'b1);

    // disarm+ack together in FIRED, then rst while ARMED with cond true
    disarm = 1'b1; ack = 1'b1;
    tick();
    disarm = 1'b0; ack = 1'b0;
    chk("da_alarm", alarm0, 1'b0);
    chk("da_armed", armed0, 1'b0);
    a = 4'd12; arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("pre_rst_armed", armed0, 1'b1);
    rst = 1'b1;
    tick();
    chk("rst_arm_hit", hit0, 1'b0);
    chk("rst_arm_armed", armed0, 1'b0);
    chk("rst_arm_ge", ge0, 1'b0);
    rst = 1'b0;
    tick();
    chk("post_rst_hit", hit0, 1'b0);
    chk("post_rst_alarm", alarm0, 1'b0);
    chk("post_rst_ge_valid", ge0, 1'b1);
    chk("post_rst_eq", eq0, 1'b0);

    // cond already true when arm accepted: fires one edge after ARMED
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("pretrue_armed", armed0, 1'b1);
    tick();
    chk("pretrue_hit", hit0, 1'b1);

    // a=0, T=0, mode a<T never fires; all-ones compare
    disarm = 1'b1; mode = 2'b11; a = 4'd0;
    tick();
    disarm = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    tick();
    chk("lt_zero_no_fire", alarm0, 1'b0);
    chk("lt_zero_armed", armed0, 1'b1);
    chk("zero_eq", eq0, 1'b1);
    load = 1'b1; target_in = 4'hF; a = 4'hF;
    tick();
    load = 1'b0;
    tick();
    chk("ones_ge", ge0, 1'b1);
    chk("ones_eq", eq0, 1'b1);

    // WIDTH=16 all-ones: a>T must not fire, a>=T must
    disarm = 1'b1; load16 = 1'b1; t16 = 16'hFFFF; a16 = 16'hFFFF; mode16 = 2'b10;
    tick();
    disarm = 1'b0; load16 = 1'b0;
    tick();
    chk("w16_ge", ge2, 1'b1);
    chk("w16_eq", eq2, 1'b1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    tick();
    chk("w16_gt_no_fire", alarm2, 1'b0);
    chk("w16_armed", armed2, 1'b1);
    mode16 = 2'b00;
    tick();
    chk("w16_ge_hit", hit2, 1'b1);
    chk("w16_ge_alarm", alarm2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/compare_alarm_unit.md
COMPARE_ALARM_UNIT -- requirements
Module: compare_alarm_unit

Interface
REQ-001 Parameter WIDTH, default 4: bit width of compared value and target, legal 2..16.
REQ-002 Parameter AUTO_REARM, default 0: 1 = return to ARMED from FIRED when condition deasserts; 0 = wait for ack.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a  input  WIDTH  live value (e.g. stopwatch count), unsigned.
REQ-006 target_in  input  WIDTH  new target value, unsigned.
REQ-007 load  input  1  capture target_in into target register.
REQ-008 mode  input  2  fire condition: 00 a>=T, 01 a==T, 10 a>T, 11 a<T.
REQ-009 arm  input  1  request IDLE->ARMED.
REQ-010 disarm  input  1  force IDLE from any state.
REQ-011 ack  input  1  acknowledge alarm; FIRED->IDLE.
REQ-012 ge  output  1  registered a>=T.
REQ-013 eq  output  1  registered a==T.
REQ-014 hit_pulse  output  1  one-cycle pulse on entry to FIRED.
REQ-015 alarm  output  1  high while in FIRED.
REQ-016 armed  output  1  high while in ARMED.

Function
REQ-017 Target register T (WIDTH bits) SHALL load target_in on any edge with load=1, in any state; the new T is used for compare from the next edge.
REQ-018 Compare stage SHALL register ge=(a>=T) and eq=(a==T) every edge; latency 1 cycle from a/T to ge/eq.
REQ-019 Condition cond SHALL derive only from registered ge/eq: 00 ge; 01 eq; 10 ge&~eq; 11 ~ge.
REQ-020 FSM states SHALL be IDLE, ARMED, FIRED; encoding implementation-defined.
REQ-021 IDLE: arm=1 and disarm=0 -> ARMED; else stay.
REQ-022 ARMED: disarm=1 -> IDLE; else cond=1 -> FIRED; else stay.
REQ-023 FIRED: disarm=1 or ack=1 -> IDLE; else AUTO_REARM=1 and cond=0 -> ARMED; else stay.
REQ-024 Priority per edge SHALL be rst > disarm > ack > cond/arm.
REQ-025 hit_pulse SHALL be registered, high exactly one cycle following each ARMED->FIRED transition; never high two consecutive cycles.
REQ-026 Total latency a-change to hit_pulse SHALL be 2 edges (compare register + FSM edge).
REQ-027 arm while ARMED or FIRED SHALL be ignored.
REQ-028 Condition already true when arm is accepted SHALL fire one edge after entering ARMED.
REQ-029 Loading T while ARMED SHALL not fire on stale compare: compare for the new T appears after 1 edge; FSM uses whatever ge/eq hold at each edge.
REQ-030 Arithmetic SHALL be unsigned; a=all-ones vs T=all-ones yields ge=1, eq=1; a=0, T=0 with mode 11 never fires.

Reset
REQ-031 On rst=1 at an edge: state=IDLE, T=0, ge=0, eq=0, hit_pulse=0, alarm=0, armed=0.
REQ-032 rst mid-FIRED or mid-ARMED SHALL abort with no hit_pulse on that or the next edge.
REQ-033 After reset release, first valid ge/eq SHALL appear 1 edge later.

Verification
REQ-034 WIDTH=4, load T=9, mode=00, arm, sweep a 0..15 -> hit_pulse once, 2 edges after a=9; alarm stays high until ack.
REQ-035 mode=01, T=5, a steps 3,4,6 (skipping 5) -> no hit; then a=5 -> hit_pulse, eq=1.
REQ-036 AUTO_REARM=1, mode=00, T=7, a toggles 8,2,8 -> two hit_pulses, armed high between them.
REQ-037 ARMED with a=3, T=3 loaded to 10 same cycle as arm, mode=00 -> no hit until a>=10.
REQ-038 disarm and ack together in FIRED, plus rst asserted in ARMED with cond true -> IDLE, hit_pulse=0, all outputs at reset values.
REQ-039 WIDTH=16, T=16'hFFFF, a=16'hFFFF, mode=10 -> no fire; mode=00 -> fire.
